dmem_arbiter: RTL

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter_pkg.sv | 32 +++
 rtl/dmem_addr_check.sv | 14 +
 rtl/dmem_arbiter.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared data-memory map: segment defaults, arbiter owner encoding and the
// segment membership helper used by address decoders.
package dmem_arbiter_pkg;

    localparam logic [31:0] DMEM_DATA_START = 32'h1000_0000;
    localparam logic [31:0] DMEM_DATA_WORDS = 32'h0004_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } owner_t;

    typedef enum logic {
        WIN_M0 = 1'b0,
        WIN_M1 = 1'b1
    } winner_t;

    // 34-bit compare so a segment ending at 4 GiB cannot wrap.
    function automatic logic in_segment(input logic [31:0] addr,
                                        input logic [31:0] base,
                                        input logic [31:0] words);
        logic [33:0] lo;
        logic [33:0] hi;
        logic [33:0] a;
        lo = {2'b00, base};
        hi = lo + {words, 2'b00};
        a  = {2'b00, addr};
        return (a >= lo) && (a < hi);
    endfunction

endpackage

// File: rtl/dmem_addr_check.sv
// Data-segment range check: valid when addr lies inside the configured segment.
module dmem_addr_check
    import dmem_arbiter_pkg::*;
#(
    parameter logic [31:0] DATA_START = DMEM_DATA_START,
    parameter logic [31:0] DATA_WORDS = DMEM_DATA_WORDS
) (
    input  logic [31:0] addr,
    output logic        valid
);

    assign valid = in_segment(addr, DATA_START, DATA_WORDS);

endmodule

// File: rtl/dmem_arbiter.sv
// Two-master data-memory arbiter: round-robin with an m1 burst lock, registered
// grants, and a shared combinational memory port driven by the current owner.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter logic [31:0] DATA_START = DMEM_DATA_START,
    parameter logic [31:0] DATA_WORDS = DMEM_DATA_WORDS,
    parameter int unsigned MAX_LOCK   = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_req,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic        m0_word_we,
    input  logic        m0_byte_we,
    input  logic        m1_req,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic        m1_word_we,
    input  logic        m1_byte_we,
    input  logic        m1_lock,
    output logic        m0_gnt,
    output logic        m1_gnt,
    output logic [31:0] m0_rdata,
    output logic [31:0] m1_rdata,
    output logic        m0_err,
    output logic        m1_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_word_we,
    output logic        mem_byte_we,
    input  logic [31:0] mem_rdata,
    output logic [15:0] conflict_cnt
);

    localparam int unsigned       LOCK_W     = $clog2(MAX_LOCK + 1);
    localparam logic [LOCK_W-1:0] LOCK_LIMIT = LOCK_W'(MAX_LOCK - 1);

    owner_t            owner, next_owner;
    winner_t           last_winner, next_winner;
    logic [LOCK_W-1:0] lock_cnt, next_lock;
    logic [15:0]       next_conflict;
    logic              lock_hold;

    logic              sel_req;
    logic [31:0]       sel_addr;
    logic [31:0]       sel_wdata;
    logic              sel_word_we;
    logic              sel_byte_we;
    logic              addr_ok;

    always_ff @(posedge clk) begin
        if (reset) begin
            owner        <= IDLE;
            last_winner  <= WIN_M1;
            lock_cnt     <= '0;
            conflict_cnt <= '0;
        end else begin
            owner        <= next_owner;
            last_winner  <= next_winner;
            lock_cnt     <= next_lock;
            conflict_cnt <= next_conflict;
        end
    end

    always_comb begin
        next_owner    = IDLE;
        next_lock     = '0;
        next_winner   = last_winner;
        next_conflict = conflict_cnt;
        lock_hold     = (owner == OWN1) && m1_req && m1_lock && (lock_cnt < LOCK_LIMIT);

        if (lock_hold) begin
            next_owner = OWN1;
            next_lock  = lock_cnt + 1'b1;
        end else begin
            // An expired lock with m0 waiting always falls through to OWN0:
            // owning OWN1 implies last_winner is m1, so round-robin picks m0.
            unique case ({m1_req, m0_req})
                2'b01:   next_owner = OWN0;
                2'b10:   next_owner = OWN1;
                2'b11:   next_owner = (last_winner == WIN_M1) ? OWN0 : OWN1;
                default: next_owner = IDLE;
            endcase
            if ((owner == OWN1) && (next_owner == OWN1) && m1_lock)
                next_lock = lock_cnt;
        end

        if (next_owner == OWN0)
            next_winner = WIN_M0;
        else if (next_owner == OWN1)
            next_winner = WIN_M1;

        if (m0_req && m1_req && (conflict_cnt != 16'hFFFF))
            next_conflict = conflict_cnt + 16'd1;
    end

    always_comb begin
        sel_req     = 1'b0;
        sel_addr    = '0;
        sel_wdata   = '0;
        sel_word_we = 1'b0;
        sel_byte_we = 1'b0;
        unique case (owner)
            OWN0: begin
                sel_req     = m0_req;
                sel_addr    = m0_addr;
                sel_wdata   = m0_wdata;
                sel_word_we = m0_word_we;
                sel_byte_we = m0_byte_we;
            end
            OWN1: begin
                sel_req     = m1_req;
                sel_addr    = m1_addr;
                sel_wdata   = m1_wdata;
                sel_word_we = m1_word_we;
                sel_byte_we = m1_byte_we;
            end
            default: ;
        endcase
    end

    dmem_addr_check #(
        .DATA_START(DATA_START),
        .DATA_WORDS(DATA_WORDS)
    ) u_addr_check (
        .addr (sel_addr),
        .valid(addr_ok)
    );

    always_comb begin
        m0_gnt      = (owner == OWN0);
        m1_gnt      = (owner == OWN1);
        m0_rdata    = m0_gnt ? mem_rdata : '0;
        m1_rdata    = m1_gnt ? mem_rdata : '0;
        m0_err      = m0_gnt && !addr_ok;
        m1_err      = m1_gnt && !addr_ok;
        mem_addr    = sel_req ? sel_addr  : '0;
        mem_wdata   = sel_req ? sel_wdata : '0;
        // Dropped req aborts the access; word enable masks byte enable.
        mem_word_we = sel_req && sel_word_we && addr_ok;
        mem_byte_we = sel_req && sel_byte_we && !sel_word_we && addr_ok;
    end

endmodule
